// File: rtl/combo_vector_checker.sv
// On-chip self-test driver for the 5-input combinational block z = (a&b) | ((c^d)&~e).
// Sweeps every input vector, samples the response after a settle window, and scores it against a truth table.
module combo_vector_checker #(
    parameter int                  N_IN   = 5,
    parameter logic [2**N_IN-1:0]  TRUTH  = 32'hFF141414,
    parameter int                  SETTLE = 2,
    parameter int                  ERR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_z,
    output logic [N_IN-1:0]   vec_o,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    localparam int              CNT_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN:0]   LAST_IDX = (N_IN+1)'(2**N_IN - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state, state_n;
    // One extra bit so the terminal compare happens before any wrap.
    logic [N_IN:0]     idx, idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [N_IN-1:0]   vec_n;
    logic              busy_n, done_n, pass_n;
    logic [ERR_W-1:0]  err_n;
    logic              fail_valid_n;
    logic [N_IN-1:0]   fail_vec_n;
    logic              mismatch;

    assign mismatch = (dut_z != TRUTH[idx[N_IN-1:0]]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        vec_n        = vec_o;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        err_n        = err_cnt;
        fail_valid_n = fail_valid;
        fail_vec_n   = fail_vec;

        if (abort) begin
            // Results of the aborted run stay visible; only status is dropped.
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            pass_n  = 1'b0;
            vec_n   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n      = S_SETTLE;
                        idx_n        = '0;
                        cnt_n        = '0;
                        vec_n        = '0;
                        err_n        = '0;
                        fail_valid_n = 1'b0;
                        fail_vec_n   = '0;
                        busy_n       = 1'b1;
                        done_n       = 1'b0;
                        pass_n       = 1'b0;
                    end
                end
                S_SETTLE: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_END) state_n = S_CHECK;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != ERR_MAX) err_n = err_cnt + ERR_W'(1);
                        if (!fail_valid) begin
                            fail_valid_n = 1'b1;
                            fail_vec_n   = idx[N_IN-1:0];
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                    end else begin
                        state_n = S_SETTLE;
                        idx_n   = idx + (N_IN+1)'(1);
                        cnt_n   = '0;
                        vec_n   = idx_n[N_IN-1:0];
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            cnt        <= '0;
            vec_o      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            idx        <= idx_n;
            cnt        <= cnt_n;
            vec_o      <= vec_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_cnt    <= err_n;
            fail_valid <= fail_valid_n;
            fail_vec   <= fail_vec_n;
        end
    end

endmodule
